// File: rtl/seg_scan_if.sv
// Handshake and display-pin bundle for the seven-segment scan controller.
interface seg_scan_if #(
   parameter int DIGITS = 4
) ();
   logic                  enable;
   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp_mask;
   logic                  load_ack;
   logic                  frame_tick;
   logic [DIGITS-1:0]     anodes;
   logic [6:0]            segs;
   logic                  dp;

   modport master (
      output enable,
      output load,
      output value,
      output dp_mask,
      input  load_ack,
      input  frame_tick,
      input  anodes,
      input  segs,
      input  dp
   );

   modport slave (
      input  enable,
      input  load,
      input  value,
      input  dp_mask,
      output load_ack,
      output frame_tick,
      output anodes,
      output segs,
      output dp
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with guard blanking and frame-synchronous commit.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module seg_scan_ctrl #(
   parameter int DIGITS       = 4,
   parameter int TICK_DIV     = 357142,
   parameter int BLANK_CYCLES = 16
) (
   input logic       clk,
   input logic       reset,
   seg_scan_if.slave bus
);

   localparam int SHOW_CYCLES = TICK_DIV - BLANK_CYCLES;
   localparam int CNT_W       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int DIG_W       = $clog2(DIGITS);

   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
   localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GUARD = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t               state, state_n;
   logic [DIG_W-1:0]     digit, digit_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic                 commit;

   logic [4*DIGITS-1:0]  pend_value;
   logic [DIGITS-1:0]    pend_dp;
   logic                 pend_valid;
   logic [4*DIGITS-1:0]  disp_value;
   logic [DIGITS-1:0]    disp_dp;

   logic [DIGITS-1:0]    anodes_n;
   logic [6:0]           segs_n;
   logic                 dp_n;
   logic                 lead_blank;
   logic [3:0]           nibble;

   // Active-low segment pattern, bit 6 = g down to bit 0 = a.
   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      case (nib)
         4'h0:    hex_decode = 7'b1000000;
         4'h1:    hex_decode = 7'b1111001;
         4'h2:    hex_decode = 7'b0100100;
         4'h3:    hex_decode = 7'b0110000;
         4'h4:    hex_decode = 7'b0011001;
         4'h5:    hex_decode = 7'b0010010;
         4'h6:    hex_decode = 7'b0000010;
         4'h7:    hex_decode = 7'b1111000;
         4'h8:    hex_decode = 7'b0000000;
         4'h9:    hex_decode = 7'b0010000;
         4'hA:    hex_decode = 7'b0001000;
         4'hB:    hex_decode = 7'b0000011;
         4'hC:    hex_decode = 7'b1000110;
         4'hD:    hex_decode = 7'b0100001;
         4'hE:    hex_decode = 7'b0000110;
         default: hex_decode = 7'b0001110;
      endcase
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   // Index of the highest nonzero nibble; 0 when the whole value is zero so digit 0 still shows.
   function automatic logic [DIG_W-1:0] msd_index(input logic [4*DIGITS-1:0] v);
      msd_index = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] != 4'h0) msd_index = DIG_W'(i);
      end
   endfunction

   assign lead_blank = (digit_n > msd_index(disp_value));
`else
   assign lead_blank = 1'b0;
`endif

   // Next-state: slot sequencing and frame-boundary commit detection.
   always_comb begin
      state_n = state;
      digit_n = digit;
      cnt_n   = cnt + CNT_W'(1);
      commit  = 1'b0;
      case (state)
         IDLE: begin
            cnt_n   = '0;
            digit_n = '0;
            if (bus.enable) begin
               state_n = GUARD;
               commit  = 1'b1;
            end
         end
         GUARD: begin
            if (cnt == GUARD_LAST) begin
               state_n = SHOW;
               cnt_n   = '0;
            end
         end
         SHOW: begin
            if (cnt == SHOW_LAST) begin
               state_n = GUARD;
               cnt_n   = '0;
               if (digit == DIG_LAST) begin
                  digit_n = '0;
                  commit  = 1'b1;
               end else begin
                  digit_n = digit + DIG_W'(1);
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            digit_n = '0;
         end
      endcase
      if (!bus.enable) begin
         state_n = IDLE;
         digit_n = '0;
         cnt_n   = '0;
         commit  = 1'b0;
      end
   end

   // Output decode from the next state so the pins are registered.
   // The display buffer only changes on GUARD entry, which is blanked, so the current copy is safe here.
   always_comb begin
      anodes_n = '1;
      segs_n   = 7'h7F;
      dp_n     = 1'b1;
      nibble   = disp_value[{digit_n, 2'b00} +: 4];
      if (state_n == SHOW) begin
         anodes_n[digit_n] = 1'b0;
         segs_n            = lead_blank ? 7'h7F : hex_decode(nibble);
         dp_n              = ~disp_dp[digit_n];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         digit          <= '0;
         cnt            <= '0;
         pend_value     <= '0;
         pend_dp        <= '0;
         pend_valid     <= 1'b0;
         disp_value     <= '0;
         disp_dp        <= '0;
         bus.anodes     <= '1;
         bus.segs       <= 7'h7F;
         bus.dp         <= 1'b1;
         bus.load_ack   <= 1'b0;
         bus.frame_tick <= 1'b0;
      end else begin
         state <= state_n;
         digit <= digit_n;
         cnt   <= cnt_n;

         // A load in the commit cycle lands in pending after the old contents are committed.
         if (bus.load) begin
            pend_value <= bus.value;
            pend_dp    <= bus.dp_mask;
            pend_valid <= 1'b1;
         end else if (commit) begin
            pend_valid <= 1'b0;
         end

         if (commit && pend_valid) begin
            disp_value <= pend_value;
            disp_dp    <= pend_dp;
         end

         bus.load_ack   <= commit & pend_valid;
         bus.frame_tick <= commit;
         bus.anodes     <= anodes_n;
         bus.segs       <= segs_n;
         bus.dp         <= dp_n;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2 (frame = 32 cycles).
module tb_seg_scan_ctrl;

   localparam int DIGITS = 4;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   int   n_ack;
   int   n_ft;
   int   n_bad;

   seg_scan_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_ctrl #(
      .DIGITS       (DIGITS),
      .TICK_DIV     (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ_SEG = 7'h7F;
`else
   localparam logic [6:0] LZ_SEG = 7'b1000000;
`endif

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pins(input string tag, input logic [3:0] an, input logic [6:0] sg,
                           input logic d);
      chk({tag, "_anodes"}, 32'(bus.anodes), 32'(an));
      chk({tag, "_segs"},   32'(bus.segs),   32'(sg));
      chk({tag, "_dp"},     32'(bus.dp),     32'(d));
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      reset        = 1'b1;
      bus.enable   = 1'b0;
      bus.load     = 1'b0;
      bus.value    = '0;
      bus.dp_mask  = '0;

      // Reset and idle.
      tick(3);
      chk_pins("rst", 4'hF, 7'h7F, 1'b1);
      chk("rst_ack", 32'(bus.load_ack), 0);
      chk("rst_ft", 32'(bus.frame_tick), 0);
      reset = 1'b0;
      n_ft  = 0;
      n_bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         n_ft  += int'(bus.frame_tick);
         n_bad += int'(bus.anodes != 4'hF || bus.segs != 7'h7F || bus.dp != 1'b1);
      end
      chk("idle_ft_count", 32'(n_ft), 0);
      chk("idle_pins_bad", 32'(n_bad), 0);

      // Load 1234 then enable: frame position 0 is the first GUARD entry.
      bus.load    = 1'b1;
      bus.value   = 16'h1234;
      bus.dp_mask = 4'b0010;
      tick(1);
      bus.load    = 1'b0;
      bus.enable  = 1'b1;
      tick(1);
      chk("f1_ft", 32'(bus.frame_tick), 1);
      chk("f1_ack", 32'(bus.load_ack), 1);
      chk("f1_guard_an", 32'(bus.anodes), 32'hF);
      tick(1);
      chk("f1_p1_ft", 32'(bus.frame_tick), 0);
      chk("f1_p1_an", 32'(bus.anodes), 32'hF);
      tick(1);
      chk_pins("f1_d0", 4'b1110, 7'b0011001, 1'b1);
      tick(5);
      chk("f1_d0_last_an", 32'(bus.anodes), 32'hE);
      tick(1);
      chk("f1_d1_guard_an", 32'(bus.anodes), 32'hF);
      tick(2);
      chk_pins("f1_d1", 4'b1101, 7'b0110000, 1'b0);
      tick(8);
      chk_pins("f1_d2", 4'b1011, 7'b0100100, 1'b1);
      tick(8);
      chk_pins("f1_d3", 4'b0111, 7'b1111001, 1'b1);
      tick(5);
      chk("f1_p31_ft", 32'(bus.frame_tick), 0);
      tick(1);
      chk("f2_ft", 32'(bus.frame_tick), 1);
      chk("f2_ack", 32'(bus.load_ack), 0);

      // Two loads within one frame: single ack, later value wins.
      tick(3);
      bus.load    = 1'b1;
      bus.value   = 16'hAAAA;
      bus.dp_mask = 4'b1111;
      tick(1);
      bus.value   = 16'h00F0;
      bus.dp_mask = 4'b0000;
      tick(1);
      bus.load    = 1'b0;
      n_ack       = 0;
      for (int i = 0; i < 27; i++) begin
         tick(1);
         n_ack += int'(bus.load_ack);
      end
      chk("dbl_ack_count", 32'(n_ack), 1);
      chk("dbl_ack_at_frame", 32'(bus.load_ack), 1);
      chk("dbl_ft", 32'(bus.frame_tick), 1);
      tick(2);
      chk_pins("dbl_d0", 4'b1110, 7'b1000000, 1'b1);
      tick(8);
      chk_pins("dbl_d1", 4'b1101, 7'b0001110, 1'b1);
      tick(8);
      chk_pins("dbl_d2", 4'b1011, LZ_SEG, 1'b1);
      tick(8);
      chk_pins("dbl_d3", 4'b0111, LZ_SEG, 1'b1);
      tick(6);
      chk("dbl_next_ack", 32'(bus.load_ack), 0);

      // Load in the exact commit cycle while pend_valid=1.
      tick(10);
      bus.load  = 1'b1;
      bus.value = 16'h5678;
      tick(1);
      bus.load  = 1'b0;
      tick(20);
      bus.load  = 1'b1;
      bus.value = 16'h9ABC;
      tick(1);
      bus.load  = 1'b0;
      chk("cc_ack_old", 32'(bus.load_ack), 1);
      chk("cc_ft", 32'(bus.frame_tick), 1);
      tick(2);
      chk("cc_old_d0_segs", 32'(bus.segs), 32'(7'b0000000));
      tick(30);
      chk("cc_ack_new", 32'(bus.load_ack), 1);
      tick(2);
      chk_pins("cc_new_d0", 4'b1110, 7'b1000110, 1'b1);

      // Drop enable mid-SHOW of digit 2, then restart.
      tick(18);
      chk("drop_d2_an", 32'(bus.anodes), 32'hB);
      bus.enable = 1'b0;
      tick(1);
      chk_pins("drop_idle", 4'hF, 7'h7F, 1'b1);
      tick(3);
      chk("drop_idle_hold_an", 32'(bus.anodes), 32'hF);
      bus.enable = 1'b1;
      tick(1);
      chk("re_ft", 32'(bus.frame_tick), 1);
      chk("re_ack", 32'(bus.load_ack), 0);
      tick(2);
      chk_pins("re_d0", 4'b1110, 7'b1000110, 1'b1);

      // Reset while pend_valid=1: pending discarded, display cleared.
      bus.load    = 1'b1;
      bus.value   = 16'h1111;
      bus.dp_mask = 4'b1111;
      tick(1);
      bus.load    = 1'b0;
      tick(5);
      reset      = 1'b1;
      bus.enable = 1'b0;
      tick(1);
      chk_pins("mid_rst", 4'hF, 7'h7F, 1'b1);
      chk("mid_rst_ack", 32'(bus.load_ack), 0);
      chk("mid_rst_ft", 32'(bus.frame_tick), 0);
      reset = 1'b0;
      tick(1);
      bus.enable = 1'b1;
      tick(1);
      chk("post_rst_ft", 32'(bus.frame_tick), 1);
      chk("post_rst_ack", 32'(bus.load_ack), 0);
      tick(2);
      chk_pins("post_rst_d0", 4'b1110, 7'b1000000, 1'b1);
      tick(8);
      chk_pins("post_rst_d1", 4'b1101, LZ_SEG, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
